// File: rtl/uart_tx_periph_if.sv
// Data-bus interface for the memory-mapped UART transmitter.
//   req_i    : request, already address-decoded for this block
//   gnt_o    : grant, the same cycle as the request
//   we_i     : write enable
//   be_i     : byte enables
//   addr_i   : byte address (only [3:2] is decoded)
//   wdata_i  : write data
//   rvalid_o : response valid, one cycle after every granted request
//   rdata_o  : registered read data
//   dbg_state: current TX FSM state (IDLE=0, START=1, DATA=2, STOP=3)
// Handshake: a request is taken in any cycle req_i is high, and gnt_o
// follows req_i combinationally. Every granted request, read or write,
// mapped or not, gets exactly one rvalid_o pulse in the following cycle.
// There is no back-pressure.
interface uart_tx_periph_if;
    logic        req_i;
    logic        gnt_o;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic [1:0]  dbg_state;

    modport master (
        output req_i, we_i, be_i, addr_i, wdata_i,
        input  gnt_o, rvalid_o, rdata_o, dbg_state
    );

    modport slave (
        input  req_i, we_i, be_i, addr_i, wdata_i,
        output gnt_o, rvalid_o, rdata_o, dbg_state
    );
endinterface

// File: rtl/uart_tx_periph.sv
// Memory-mapped 8N1 UART transmitter.
// Bus writes push bytes into a TX FIFO. A baud-timed FSM serialises the
// bytes onto tx_o, LSB first.
//   clk_i  : system clock
//   rst_ni : asynchronous active-low reset
//   bus    : data-bus slave port (see uart_tx_periph_if)
//   tx_o   : serial output, idle high
// Registers (word offsets):
//   0x0 TXDATA (W)  : push wdata[7:0] when be[0] is set
//   0x4 STATUS (R)  : {overflow, busy, empty, full}; writing bit3 with be[0] clears overflow
//   0x8 DIV    (RW) : cycles-per-bit minus 1, bits [15:0]
//   0xC reserved
module uart_tx_periph #(
    parameter int ClkFreq   = 50000000,
    parameter int BaudRate  = 115200,
    parameter int FifoDepth = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    uart_tx_periph_if.slave  bus,
    output logic             tx_o
);
    localparam int          AW        = $clog2(FifoDepth);
    localparam logic [15:0] DivReset  = 16'(ClkFreq / BaudRate - 1);
    localparam logic [AW:0] FullCount = (AW + 1)'(FifoDepth);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    // Bus decode
    logic [1:0] reg_sel;
    logic       wr_acc, push_req, clr_ovf, div_wr;
    assign reg_sel  = bus.addr_i[3:2];
    assign wr_acc   = bus.req_i & bus.we_i;
    assign push_req = wr_acc && (reg_sel == 2'd0) && bus.be_i[0];
    assign clr_ovf  = wr_acc && (reg_sel == 2'd1) && bus.be_i[0] && bus.wdata_i[3];
    assign div_wr   = wr_acc && (reg_sel == 2'd2);
    assign bus.gnt_o = bus.req_i;

    logic unused_bits;
    assign unused_bits = ^{bus.addr_i[31:4], bus.addr_i[1:0], bus.wdata_i[31:16], bus.be_i[3:2]};

    // FIFO
    logic [7:0]    fifo_mem [FifoDepth];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          full, empty, pop, push, ovf_set;
    logic          ovf_q;
    logic [15:0]   div_q;

    assign full  = (count_q == FullCount);
    assign empty = (count_q == '0);
    // The FSM pops in the same cycle, so a full FIFO still has room.
    assign push    = push_req && (!full || pop);
    assign ovf_set = push_req && full && !pop;

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q] <= bus.wdata_i[7:0];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            div_q    <= DivReset;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
            // A set in the same cycle as a clear wins.
            if (ovf_set)      ovf_q <= 1'b1;
            else if (clr_ovf) ovf_q <= 1'b0;
            if (div_wr && bus.be_i[0]) div_q[7:0]  <= bus.wdata_i[7:0];
            if (div_wr && bus.be_i[1]) div_q[15:8] <= bus.wdata_i[15:8];
        end
    end

    // TX FSM
    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;      // cycles spent in the current bit
    logic [15:0] divl_q, divl_d;    // divisor latched for the frame in flight
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        tx_q, tx_d;
    logic        busy;

    assign busy = (state_q != IDLE) || !empty;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            divl_q  <= DivReset;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            divl_q  <= divl_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        divl_d  = divl_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_mem[rd_ptr_q];
                    divl_d  = div_q;
                    cnt_d   = '0;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == divl_q) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                    state_d = DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DATA: begin
                if (cnt_q == divl_q) begin
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        // Shift so the next bit to send is always shift_q[0].
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            STOP: begin
                if (cnt_q == divl_q) begin
                    cnt_d = '0;
                    if (!empty) begin
                        // Chain straight into the next frame without an idle bit.
                        pop     = 1'b1;
                        shift_d = fifo_mem[rd_ptr_q];
                        divl_d  = div_q;
                        tx_d    = 1'b0;
                        state_d = START;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign tx_o          = tx_q;
    assign bus.dbg_state = state_q;

    // Bus response
    logic [31:0] rdata_d, rdata_q;
    logic        rvalid_q;

    always_comb begin
        rdata_d = '0;
        if (bus.req_i && !bus.we_i) begin
            case (reg_sel)
                2'd1:    rdata_d = {28'd0, ovf_q, busy, empty, full};
                2'd2:    rdata_d = {16'd0, div_q};
                default: rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= bus.req_i;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;
endmodule

// File: tb/tb_uart_tx_periph.sv
// Directed bench for uart_tx_periph (default parameters, DIV reset 433).
module tb_uart_tx_periph;
    logic clk;
    logic rst_n;
    logic tx;
    int   total;
    int   bad;

    uart_tx_periph_if bus();

    uart_tx_periph #(
        .ClkFreq  (50000000),
        .BaudRate (115200),
        .FifoDepth(8)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus),
        .tx_o  (tx)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_bus();
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.be_i    = 4'h0;
        bus.addr_i  = 32'h0;
        bus.wdata_i = 32'h0;
    endtask

    task automatic apply_reset();
        idle_bus();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Driver: one request cycle, returns grant and the response seen one cycle later.
    task automatic bus_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] be, output logic gnt, output logic rv,
                              output logic [31:0] rd);
        @(posedge clk);
        #1;
        bus.req_i   = 1'b1;
        bus.we_i    = we;
        bus.be_i    = be;
        bus.addr_i  = addr;
        bus.wdata_i = wdata;
        #1 gnt = bus.gnt_o;
        @(posedge clk);
        #1;
        rv = bus.rvalid_o;
        rd = bus.rdata_o;
        idle_bus();
    endtask

    task automatic test_reset();
        logic g, rv;
        logic [31:0] rd;
        apply_reset();
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b expected 1", tx); end
        total++;
        if (bus.rvalid_o !== 1'b0) begin bad++; $display("FAIL reset_rvalid: got %b expected 0", bus.rvalid_o); end
        total++;
        if (bus.rdata_o !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %0h expected 0", bus.rdata_o); end
        bus_access(1'b0, 32'h4, 32'h0, 4'hF, g, rv, rd);
        total++;
        if (g !== 1'b1) begin bad++; $display("FAIL reset_gnt: got %b expected 1", g); end
        total++;
        if (rv !== 1'b1) begin bad++; $display("FAIL reset_status_rvalid: got %b expected 1", rv); end
        total++;
        if (rd !== 32'h2) begin bad++; $display("FAIL reset_status: got %0h expected 2", rd); end
        @(posedge clk);
        #1;
        total++;
        if (bus.rvalid_o !== 1'b0) begin bad++; $display("FAIL rvalid_one_cycle: got %b expected 0", bus.rvalid_o); end
        bus_access(1'b0, 32'h8, 32'h0, 4'hF, g, rv, rd);
        total++;
        if (rd !== 32'd433) begin bad++; $display("FAIL reset_div: got %0d expected 433", rd); end
    endtask

    task automatic test_frame_a5();
        logic g, rv;
        logic [31:0] rd;
        logic [7:0] data;
        logic exp_bit;
        int b;
        data = 8'hA5;
        bus_access(1'b1, 32'h8, 32'h3, 4'hF, g, rv, rd);
        total++;
        if (rv !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL div_write_resp: got rv=%b rd=%0h expected rv=1 rd=0", rv, rd); end
        bus_access(1'b1, 32'h0, {24'h0, data}, 4'h1, g, rv, rd);
        total++;
        if (rv !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL txdata_write_resp: got rv=%b rd=%0h expected rv=1 rd=0", rv, rd); end
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL a5_not_early: got %b expected 1", tx); end
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            b = i / 4;
            if (b == 0)      exp_bit = 1'b0;
            else if (b == 9) exp_bit = 1'b1;
            else             exp_bit = data[b-1];
            total++;
            if (tx !== exp_bit) begin bad++; $display("FAIL a5_bit cyc=%0d: got %b expected %b", i, tx, exp_bit); end
            if (i == 10) begin
                bus.req_i  = 1'b1;
                bus.we_i   = 1'b0;
                bus.be_i   = 4'hF;
                bus.addr_i = 32'h4;
            end
            if (i == 11) begin
                idle_bus();
                total++;
                if (bus.rvalid_o !== 1'b1 || bus.rdata_o !== 32'h6) begin
                    bad++;
                    $display("FAIL a5_busy_status: got rv=%b rd=%0h expected rv=1 rd=6", bus.rvalid_o, bus.rdata_o);
                end
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (tx !== 1'b1 || bus.dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL a5_end: got tx=%b state=%0d expected tx=1 state=0", tx, bus.dbg_state);
        end
        bus_access(1'b0, 32'h4, 32'h0, 4'hF, g, rv, rd);
        total++;
        if (rd !== 32'h2) begin bad++; $display("FAIL a5_status_after: got %0h expected 2", rd); end
    endtask

    task automatic test_back_to_back();
        logic g, rv;
        logic [31:0] rd;
        logic [7:0] bytes [3];
        logic exp_bit;
        int f, b;
        bytes[0] = 8'h01;
        bytes[1] = 8'h02;
        bytes[2] = 8'h03;
        bus_access(1'b1, 32'h8, 32'h0, 4'hF, g, rv, rd);
        @(posedge clk);
        #1;
        bus.req_i  = 1'b1;
        bus.we_i   = 1'b1;
        bus.be_i   = 4'h1;
        bus.addr_i = 32'h0;
        bus.wdata_i = 32'h01;
        @(posedge clk);
        #1 bus.wdata_i = 32'h02;
        @(posedge clk);
        #1 bus.wdata_i = 32'h03;
        for (int i = 0; i < 30; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (i == 1) idle_bus();
            f = i / 10;
            b = i % 10;
            if (b == 0)      exp_bit = 1'b0;
            else if (b == 9) exp_bit = 1'b1;
            else             exp_bit = bytes[f][b-1];
            total++;
            if (tx !== exp_bit) begin bad++; $display("FAIL b2b_bit cyc=%0d: got %b expected %b", i, tx, exp_bit); end
        end
        @(posedge clk);
        #1;
        total++;
        if (tx !== 1'b1 || bus.dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL b2b_end: got tx=%b state=%0d expected tx=1 state=0", tx, bus.dbg_state);
        end
    endtask

    task automatic test_overflow();
        logic g, rv;
        logic [31:0] rd;
        bus_access(1'b1, 32'h8, 32'd100, 4'hF, g, rv, rd);
        @(posedge clk);
        #1;
        bus.req_i  = 1'b1;
        bus.we_i   = 1'b1;
        bus.be_i   = 4'h1;
        bus.addr_i = 32'h0;
        for (int k = 0; k < 9; k++) begin
            bus.wdata_i = 32'h10 + k;
            @(posedge clk);
            #1;
        end
        idle_bus();
        bus_access(1'b0, 32'h4, 32'h0, 4'hF, g, rv, rd);
        total++;
        if (rd !== 32'h5) begin bad++; $display("FAIL ovf_full_status: got %0h expected 5", rd); end
        bus_access(1'b1, 32'h0, 32'h99, 4'h1, g, rv, rd);
        total++;
        if (rv !== 1'b1 || g !== 1'b1) begin bad++; $display("FAIL ovf_drop_resp: got rv=%b gnt=%b expected 1 1", rv, g); end
        bus_access(1'b0, 32'h4, 32'h0, 4'hF, g, rv, rd);
        total++;
        if (rd !== 32'hD) begin bad++; $display("FAIL ovf_status: got %0h expected d", rd); end
        bus_access(1'b1, 32'h4, 32'h8, 4'h1, g, rv, rd);
        bus_access(1'b0, 32'h4, 32'h0, 4'hF, g, rv, rd);
        total++;
        if (rd !== 32'h5) begin bad++; $display("FAIL ovf_clear: got %0h expected 5", rd); end
    endtask

    task automatic test_reset_mid_frame();
        logic g, rv;
        logic [31:0] rd;
        apply_reset();
        bus_access(1'b1, 32'h8, 32'h3, 4'hF, g, rv, rd);
        bus_access(1'b1, 32'h0, 32'h00, 4'h1, g, rv, rd);
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (bus.dbg_state !== 2'd2 || tx !== 1'b0) begin
            bad++;
            $display("FAIL mid_frame_setup: got state=%0d tx=%b expected state=2 tx=0", bus.dbg_state, tx);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL async_reset_tx: got %b expected 1", tx); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        bus_access(1'b0, 32'h4, 32'h0, 4'hF, g, rv, rd);
        total++;
        if (rd !== 32'h2) begin bad++; $display("FAIL post_reset_status: got %0h expected 2", rd); end
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (tx !== 1'b1) begin bad++; $display("FAIL post_reset_idle cyc=%0d: got %b expected 1", i, tx); end
        end
    endtask

    task automatic test_byte_enables();
        logic g, rv;
        logic [31:0] rd;
        bus_access(1'b1, 32'h0, 32'h55, 4'hE, g, rv, rd);
        bus_access(1'b0, 32'h4, 32'h0, 4'hF, g, rv, rd);
        total++;
        if (rd !== 32'h2) begin bad++; $display("FAIL be_no_push: got %0h expected 2", rd); end
        total++;
        if (tx !== 1'b1) begin bad++; $display("FAIL be_no_tx: got %b expected 1", tx); end
        bus_access(1'b0, 32'h0, 32'h0, 4'hF, g, rv, rd);
        total++;
        if (rv !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL txdata_read: got rv=%b rd=%0h expected rv=1 rd=0", rv, rd); end
        bus_access(1'b1, 32'hC, 32'hFFFF_FFFF, 4'hF, g, rv, rd);
        bus_access(1'b0, 32'hC, 32'h0, 4'hF, g, rv, rd);
        total++;
        if (rv !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL reserved_read: got rv=%b rd=%0h expected rv=1 rd=0", rv, rd); end
        bus_access(1'b1, 32'h8, 32'h0000_1234, 4'h1, g, rv, rd);
        bus_access(1'b0, 32'h8, 32'h0, 4'hF, g, rv, rd);
        total++;
        if (rd !== 32'h0134) begin bad++; $display("FAIL div_low_byte: got %0h expected 134", rd); end
        bus_access(1'b1, 32'h8, 32'h0000_AB00, 4'h2, g, rv, rd);
        bus_access(1'b0, 32'h8, 32'h0, 4'hF, g, rv, rd);
        total++;
        if (rd !== 32'hAB34) begin bad++; $display("FAIL div_high_byte: got %0h expected ab34", rd); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        idle_bus();
        test_reset();
        test_frame_a5();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        test_byte_enables();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_periph.md
Name: uart_tx_periph

Overview:
- Memory-mapped 8N1 UART transmitter on the core data bus, alongside the SRAM and the LED register in the FPGA top.
- Decoded data-bus accesses (req/we/be/addr/wdata) push bytes into a TX FIFO and access control/status registers.
- A baud-timed FSM serialises FIFO bytes onto tx_o.
- Bus timing matches the SRAM: grant in the same cycle as the request, response one cycle later.

Parameters:
- ClkFreq, 50000000, system clock frequency in Hz.
- BaudRate, 115200, reset baud rate; reset divisor = ClkFreq/BaudRate - 1.
- FifoDepth, 8, TX FIFO entries; power of two, >= 2.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- req_i  input  1  bus request (already address-decoded for this block)
- gnt_o  output  1  grant; combinationally equals req_i
- we_i  input  1  write enable
- be_i  input  4  byte enables
- addr_i  input  32  byte address; only addr_i[3:2] decoded
- wdata_i  input  32  write data
- rvalid_o  output  1  response valid
- rdata_o  output  32  read data
- tx_o  output  1  serial output, idle high

Behaviour:
- Reset: rvalid_o=0, rdata_o=0, tx_o=1, FIFO empty, overflow=0, divisor=ClkFreq/BaudRate-1, FSM IDLE.
- Bus:
  - Every req_i is accepted in its own cycle.
  - rvalid_o=1 exactly one cycle after each accepted req, including writes and unmapped addresses.
  - rdata_o is registered; it is 0 for writes and for unmapped reads.
- Register map (word offset):
  - 0x0 TXDATA (W): if be_i[0], push wdata_i[7:0]. If the FIFO is full, drop the byte and set overflow. A push into a full FIFO is accepted if a pop occurs in the same cycle. Reads return 0.
  - 0x4 STATUS (R): bit0 full, bit1 empty, bit2 busy (FSM not IDLE or FIFO non-empty), bit3 overflow (sticky). A write with be_i[0] and wdata_i[3]=1 clears overflow. If a clear and an overflowing push occur in the same cycle, the set wins.
  - 0x8 DIV (RW): 16-bit cycles-per-bit minus 1, held in bits [15:0]. Writes honour be_i[1:0]. A value of 0 gives 1 cycle per bit.
  - 0xC: reserved; reads 0, writes ignored.
- FIFO:
  - Pointer-based, wraps modulo FifoDepth.
  - Count ranges 0..FifoDepth; full when count==FifoDepth.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx_o=1. When the FIFO is non-empty, pop the head into a shift register, latch the divisor, and move to START. The pop happens in the transition cycle.
  - START: tx_o=0 for DIV+1 cycles.
  - DATA: 8 bits, LSB first, each held DIV+1 cycles. A 3-bit bit counter runs 0..7.
  - STOP: tx_o=1 for DIV+1 cycles. At the end of STOP, a non-empty FIFO pops immediately and goes to START (no idle gap); otherwise go to IDLE.
  - tx_o is registered and changes only at bit boundaries.
  - A divisor write mid-frame takes effect at the next frame.
- Latency: a TXDATA write at cycle T into an empty FIFO with the FSM in IDLE → byte in FIFO at T+1, popped at T+1, tx_o falls at T+2.
- Reset mid-frame: tx_o returns to 1 immediately (asynchronously). FIFO contents and the partial frame are discarded.

Test Plan:
- Reset, then read STATUS and DIV → STATUS=0x2 (empty); DIV=433 for the defaults; tx_o=1; rvalid_o one cycle after each req.
- Write DIV=3, then TXDATA=0xA5 → tx_o: 4 cycles low, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 4 cycles high; start bit begins 2 cycles after the write; total frame 40 cycles; STATUS.busy=1 throughout.
- DIV=0, write 0x01, 0x02, 0x03 back-to-back → three contiguous 10-cycle frames with no idle cycle between stop and start.
- DIV=100, write 9 bytes quickly with FifoDepth=8 (first byte already popped) → all 9 accepted. A 10th write while full → dropped and STATUS=0xD (full, busy, overflow). Write STATUS=0x8 → overflow clears.
- Write TXDATA with be_i=4'b1110 → no push; read 0xC → 0; write DIV with be_i=4'b0001, value 0x00001234 → DIV low byte=0x34, upper byte unchanged.
- Assert rst_ni during DATA of a frame → tx_o=1 in the same cycle; after release, STATUS=0x2 and no further frame is transmitted.
